// File: rtl/alu_seq.sv
// alu_seq: handshaked saturating ALU with a sticky {Z,V,N} flag register and an iterative shifter.
// Latency: the result is visible 1 cycle after accept; a shift by k>0 is visible k+1 cycles after accept.
// Backpressure: result/err/flags are held while out_valid && !out_ready; in DONE, in_ready follows out_ready.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready  operation handshake from decode/register-read
//   opcode, a, b         0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB
//                        shifts take their amount from b[$clog2(WIDTH)-1:0]
//   out_valid / out_ready result handshake to writeback
//   result, err, flags   registered outputs; flags = {Z, V, N}
//
// Build option: define ALU_PADDSB_EN to implement PADDSB on opcode 7.
// Without it, opcode 7 returns result 0 with err=1 and leaves the flags untouched.

module alu_seq #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       flags
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int NBYTE = WIDTH / 8;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_RED    = 3'd3;
  localparam logic [2:0] OP_SLL    = 3'd4;
  localparam logic [2:0] OP_SRA    = 3'd5;
  localparam logic [2:0] OP_ROR    = 3'd6;
  localparam logic [2:0] OP_PADDSB = 3'd7;

  localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_ONE = SHW'(1);

  // Reject configurations the byte reduction and lane adder cannot handle.
  if ((WIDTH < 8) || (WIDTH % 8 != 0) || (LANE < 2) || (WIDTH % LANE != 0)) begin : g_param_check
    $error("alu_seq: WIDTH must be a multiple of 8 (>= 8) and LANE (>= 2) must divide WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  state_t           state;
  flags_t           flags_q;
  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0]   cnt;
  logic [2:0]       op_q;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   shamt;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // A held result frees the input side only when writeback takes it this cycle,
  // which gives back-to-back operation with no bubble.
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_shift = (opcode == OP_SLL) || (opcode == OP_SRA) || (opcode == OP_ROR);
  assign shamt    = b[SHW-1:0];
  assign flags    = flags_q;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  // One guard bit: overflow happened when the top two bits of the extended sum differ.
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] add_sat;
  logic [WIDTH-1:0] sub_sat;

  assign add_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign sub_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign add_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
  assign sub_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
  assign add_sat = add_ovf ? (add_ext[WIDTH] ? SMIN : SMAX) : add_ext[WIDTH-1:0];
  assign sub_sat = sub_ovf ? (sub_ext[WIDTH] ? SMIN : SMAX) : sub_ext[WIDTH-1:0];

  // Byte reduction: eight spare bits hold any sum of 2*NBYTE signed bytes; the
  // result keeps the low WIDTH bits, which is the sign-extended sum when it fits.
  logic [WIDTH+7:0] red_sum;

  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NBYTE; i++) begin
      red_sum = red_sum
              + {{WIDTH{a[8*i+7]}}, a[8*i +: 8]}
              + {{WIDTH{b[8*i+7]}}, b[8*i +: 8]};
    end
  end

`ifdef ALU_PADDSB_EN
  localparam int NLANE = WIDTH / LANE;

  logic [WIDTH-1:0] padd_res;

  // Each lane saturates on its own; no carry crosses a lane boundary.
  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    logic [LANE:0] lsum;
    assign lsum = {a[l*LANE+LANE-1], a[l*LANE +: LANE]}
                + {b[l*LANE+LANE-1], b[l*LANE +: LANE]};
    assign padd_res[l*LANE +: LANE] =
        (lsum[LANE] != lsum[LANE-1]) ?
          (lsum[LANE] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}}) :
          lsum[LANE-1:0];
  end
`endif

  logic [WIDTH-1:0] comb_res;
  logic             comb_err;
  logic             comb_nv;   // op owns the N and V flags
  logic             comb_v;

  always_comb begin
    comb_res = '0;
    comb_err = 1'b0;
    comb_nv  = 1'b0;
    comb_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        comb_res = add_sat;
        comb_v   = add_ovf;
        comb_nv  = 1'b1;
      end
      OP_SUB: begin
        comb_res = sub_sat;
        comb_v   = sub_ovf;
        comb_nv  = 1'b1;
      end
      OP_XOR: comb_res = a ^ b;
      OP_RED: comb_res = red_sum[WIDTH-1:0];
      // Only reached with a zero shift amount: the value passes through unchanged.
      OP_SLL, OP_SRA, OP_ROR: comb_res = a;
      OP_PADDSB: begin
`ifdef ALU_PADDSB_EN
        comb_res = padd_res;
`else
        comb_err = 1'b1;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative shifter: one bit per cycle on the latched value
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_step;

  always_comb begin
    case (op_q)
      OP_SLL:  shift_step = {sreg[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_step = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      default: shift_step = {sreg[0], sreg[WIDTH-1:1]};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      flags_q   <= '0;
      sreg      <= '0;
      cnt       <= '0;
      op_q      <= OP_ADD;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              sreg      <= a;
              cnt       <= shamt;
              op_q      <= opcode;
              out_valid <= 1'b0;
              state     <= ST_SHIFT;
            end else begin
              result    <= comb_res;
              err       <= comb_err;
              out_valid <= 1'b1;
              state     <= ST_DONE;
              // An unsupported opcode must not disturb the branch flags.
              if (!comb_err) begin
                flags_q.z <= (comb_res == '0);
                if (comb_nv) begin
                  flags_q.v <= comb_v;
                  flags_q.n <= comb_res[WIDTH-1];
                end
              end
            end
          end else if ((state == ST_DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          sreg <= shift_step;
          cnt  <= cnt - CNT_ONE;
          // The final step writes the result directly so DONE follows the k-th shift.
          if (cnt == CNT_ONE) begin
            result    <= shift_step;
            err       <= 1'b0;
            flags_q.z <= (shift_step == '0);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (directed table, random ops against a model, corner sequences).
// Latency: drives on the falling edge and samples outputs on the falling edge.
// Backpressure: exercises held results, same-cycle re-accept and reset during a shift.

module tb_alu_seq;

  localparam int W = 16;
  localparam int L = 4;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_RED    = 3'd3;
  localparam logic [2:0] OP_SLL    = 3'd4;
  localparam logic [2:0] OP_SRA    = 3'd5;
  localparam logic [2:0] OP_ROR    = 3'd6;
  localparam logic [2:0] OP_PADDSB = 3'd7;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         err;
  logic [2:0]   flags;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W), .LANE(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic from the operation definitions.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input logic [2:0] fin, output logic [W-1:0] res, output logic er,
                                output logic [2:0] fout, output int lat);
    int sa, sb, s, k, la, lb;
    int smax, smin, lmax, lmin;
    logic v;
    smax = 2 ** (W - 1) - 1;
    smin = -(2 ** (W - 1));
    lmax = 2 ** (L - 1) - 1;
    lmin = -(2 ** (L - 1));
    sa = $signed(ai);
    sb = $signed(bi);
    k  = int'(bi[$clog2(W)-1:0]);
    res = '0; er = 1'b0; fout = fin; lat = 1; v = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        s = (op == OP_ADD) ? sa + sb : sa - sb;
        if (s > smax) begin s = smax; v = 1'b1; end
        else if (s < smin) begin s = smin; v = 1'b1; end
        res  = W'(s);
        fout = {res == '0, v, res[W-1]};
      end
      OP_XOR: res = ai ^ bi;
      OP_RED: begin
        s = 0;
        for (int i = 0; i < W / 8; i++) begin
          la = $signed(ai[8*i +: 8]);
          lb = $signed(bi[8*i +: 8]);
          s  = s + la + lb;
        end
        res = W'(s);
      end
      OP_SLL: begin res = ai << k;                      lat = k + 1; end
      OP_SRA: begin res = W'(sa >>> k);                 lat = k + 1; end
      OP_ROR: begin res = (ai >> k) | (ai << (W - k));  lat = k + 1; end
      default: begin
`ifdef ALU_PADDSB_EN
        for (int l = 0; l < W / L; l++) begin
          la = $signed(ai[L*l +: L]);
          lb = $signed(bi[L*l +: L]);
          s  = la + lb;
          if (s > lmax) s = lmax;
          else if (s < lmin) s = lmin;
          res[L*l +: L] = L'(s);
        end
`else
        er = 1'b1;
`endif
      end
    endcase
    if (!er) fout[2] = (res == '0);
  endfunction

  // Offer one op (at a falling edge), check latency/busy/result, then hold
  // backpressure for 'hold' cycles. Returns at a falling edge with out_ready=1
  // and the result still valid, so a following call re-accepts back-to-back.
  task automatic run_txn(input string name, input logic [2:0] op, input logic [W-1:0] ai,
                         input logic [W-1:0] bi, input int hold, input logic [W-1:0] e_res,
                         input logic e_err, input logic [2:0] e_fl, input int e_lat);
    int guard;
    int lat;
    in_valid = 1'b1; opcode = op; a = ai; b = bi;
    #1;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk); #1; guard++;
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble the inputs: the op must already be latched.
    in_valid = 1'b0; opcode = 3'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat <= W + 2) begin
      check({name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(e_lat));
    check({name, "_result"}, 32'(result), 32'(e_res));
    check({name, "_err"}, 32'(err), 32'(e_err));
    check({name, "_flags"}, 32'(flags), 32'(e_fl));
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({name, "_hold_result"}, 32'(result), 32'(e_res));
        check({name, "_hold_flags"}, 32'(flags), 32'(e_fl));
        check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         er;
    logic [2:0]   fl;   // {Z, V, N}
    int           lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    logic [2:0]   mflags;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb, er;
    logic         ee;
    logic [2:0]   ef;
    int           el;
    int           seen;

    // Expected values worked from the operation rules; flags carry over in order.
    vecs[0]  = '{OP_ADD, 16'h7FF0, 16'h0020, 16'h7FFF, 1'b0, 3'b010, 1};
    vecs[1]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b100, 1};
    vecs[2]  = '{OP_ADD, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 3'b011, 1};
    vecs[3]  = '{OP_RED, 16'h01FF, 16'h0203, 16'h0005, 1'b0, 3'b011, 1};
    vecs[4]  = '{OP_XOR, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 3'b011, 1};
    vecs[5]  = '{OP_XOR, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b111, 1};
    vecs[6]  = '{OP_ROR, 16'h8001, 16'h0004, 16'h1800, 1'b0, 3'b011, 5};
    vecs[7]  = '{OP_SRA, 16'h8000, 16'h0003, 16'hF000, 1'b0, 3'b011, 4};
    vecs[8]  = '{OP_SLL, 16'h1234, 16'h0000, 16'h1234, 1'b0, 3'b011, 1};
    vecs[9]  = '{OP_SLL, 16'h8001, 16'h0011, 16'h0002, 1'b0, 3'b011, 2};
    vecs[10] = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 3'b001, 1};
    vecs[11] = '{OP_SUB, 16'h8000, 16'h0001, 16'h8000, 1'b0, 3'b011, 1};
    vecs[12] = '{OP_SUB, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 3'b010, 1};
`ifdef ALU_PADDSB_EN
    vecs[13] = '{OP_PADDSB, 16'h7171, 16'h1111, 16'h7272, 1'b0, 3'b010, 1};
`else
    vecs[13] = '{OP_PADDSB, 16'h7171, 16'h1111, 16'h0000, 1'b1, 3'b010, 1};
`endif
    vecs[14] = '{OP_SRA, 16'h4000, 16'h000F, 16'h0000, 1'b0, 3'b110, 16};
    vecs[15] = '{OP_RED, 16'h8080, 16'h8080, 16'hFE00, 1'b0, 3'b010, 1};
    vecs[16] = '{OP_ROR, 16'h0001, 16'h000F, 16'h0002, 1'b0, 3'b010, 16};
    vecs[17] = '{OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 3'b000, 1};
`ifdef ALU_PADDSB_EN
    vecs[18] = '{OP_PADDSB, 16'h8888, 16'h8888, 16'h8888, 1'b0, 3'b000, 1};
`else
    vecs[18] = '{OP_PADDSB, 16'h8888, 16'h8888, 16'h0000, 1'b1, 3'b000, 1};
`endif

    // ---- reset state ----
    rst_n = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, i % 3,
              vecs[i].res, vecs[i].er, vecs[i].fl, vecs[i].lat);
    end
    mflags = vecs[NV-1].fl;
    in_valid = 1'b0;
    @(negedge clk);
    check("table_drain_idle", 32'(out_valid), 32'd0);

    // ---- random ops against the model ----
    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? (16'h7FF0 | W'($urandom_range(0, 15))) : W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? (16'h8000 | W'($urandom_range(0, 15))) : W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      model(rop, ra, rb, mflags, er, ee, ef, el);
      run_txn($sformatf("rnd%0d", i), rop, ra, rb, ($urandom_range(0, 3) == 0) ? 2 : 0,
              er, ee, ef, el);
      mflags = ef;
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);

    // ---- backpressure with a waiting op, then same-cycle re-accept ----
    model(OP_ADD, 16'h7FF0, 16'h0100, mflags, er, ee, ef, el);
    mflags = ef;
    in_valid = 1'b1; opcode = OP_ADD; a = 16'h7FF0; b = 16'h0100; out_ready = 1'b0;
    @(negedge clk);
    opcode = OP_XOR; a = 16'hFF00; b = 16'h0FF0;
    for (int h = 0; h < 3; h++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'(er));
      check("bp_flags", 32'(flags), 32'(mflags));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    model(OP_XOR, 16'hFF00, 16'h0FF0, mflags, er, ee, ef, el);
    out_ready = 1'b1;
    #1;
    check("bp_same_cycle_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_no_bubble_valid", 32'(out_valid), 32'd1);
    check("bp_no_bubble_result", 32'(result), 32'(er));
    check("bp_no_bubble_flags", 32'(flags), 32'(ef));
    mflags = ef;
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // ---- reset in the middle of a long shift ----
    in_valid = 1'b1; opcode = OP_ROR; a = 16'hABCD; b = 16'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_shift_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_output", 32'(seen), 32'd0);

    // ---- still operational after the abort ----
    mflags = 3'b000;
    model(OP_ADD, 16'h0001, 16'hFFFF, mflags, er, ee, ef, el);
    run_txn("post_reset_add", OP_ADD, 16'h0001, 16'hFFFF, 0, er, ee, ef, el);
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
